// File: rtl/fc_layer5_reader.sv
// ---------------------------------------------------------------------------
// fc_layer5_reader
//
// Purpose:
//   Consumer end of the pooled layer-4 feature buffers. Once layer 4 has
//   finished, this block streams both L4 output banks (200 pooled values per
//   bank) together with the matching weights from a dual-port weight ROM. It
//   computes one fully-connected dot product per layer-5 neuron and writes
//   each saturated 12-bit result to the L5 output memory.
//
// Ports:
//   clk              clock
//   rst              synchronous, active-high reset
//   L5_en            level enable; held high for the whole run, low aborts
//   L4_read_addr     shared feature address for both L4 banks
//   L4_read_data1    bank-1 feature (kernels 0-7)
//   L4_read_data2    bank-2 feature (kernels 8-15)
//   L5_weight_addra  ROM port a address: out_idx*FEAT_PER_BANK + feat
//   L5_weight_addrb  ROM port b address: WEIGHT_BASE_B + port a address
//   L5_weight_douta  weight paired with the bank-1 feature
//   L5_weight_doutb  weight paired with the bank-2 feature
//   L5_out_addr      index of the neuron being written
//   L5_out_data      saturated neuron result
//   L5_out_wea       one-cycle write strobe per neuron
//   L5_busy          high while streaming, draining or writing
//   L5_done          high once all neurons are written, until L5_en drops
//
// Configuration:
//   L5_RELU_EN  when defined, negative saturated results are written as 0.
//               Timing is identical with or without it.
// ---------------------------------------------------------------------------
module fc_layer5_reader #(
   parameter int DATA_WIDTH    = 12,
   parameter int FEAT_PER_BANK = 200,
   parameter int NUM_OUT       = 120,
   parameter int ACC_WIDTH     = 32,
   parameter int FRAC_BITS     = 8,
   parameter int RD_LAT        = 2,
   parameter int WEIGHT_BASE_B = 24000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  L5_en,
   output logic [7:0]            L4_read_addr,
   input  logic [DATA_WIDTH-1:0] L4_read_data1,
   input  logic [DATA_WIDTH-1:0] L4_read_data2,
   output logic [15:0]           L5_weight_addra,
   output logic [15:0]           L5_weight_addrb,
   input  logic [DATA_WIDTH-1:0] L5_weight_douta,
   input  logic [DATA_WIDTH-1:0] L5_weight_doutb,
   output logic [6:0]            L5_out_addr,
   output logic [DATA_WIDTH-1:0] L5_out_data,
   output logic                  L5_out_wea,
   output logic                  L5_busy,
   output logic                  L5_done
);

   localparam int PROD_WIDTH = 2 * DATA_WIDTH;
   localparam int DRAIN_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LAT - 1);
   localparam logic [7:0]         FEAT_LAST  = 8'(FEAT_PER_BANK - 1);
   localparam logic [6:0]         OUT_LAST   = 7'(NUM_OUT - 1);
   localparam logic [15:0]        BASE_B     = 16'(WEIGHT_BASE_B);

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

   typedef enum logic [2:0] {
      IDLE,
      STREAM,
      DRAIN,
      WRITE,
      DONE
   } state_t;

   state_t                        state;
   logic [7:0]                    feat;
   logic [6:0]                    out_idx;
   logic [DRAIN_W-1:0]            drain_cnt;
   logic [RD_LAT-1:0]             valid_pipe;
   logic signed [ACC_WIDTH-1:0]   acc;

   logic signed [PROD_WIDTH-1:0]  prod_a;
   logic signed [PROD_WIDTH-1:0]  prod_b;
   logic signed [ACC_WIDTH-1:0]   mac_sum;
   logic signed [ACC_WIDTH-1:0]   acc_shift;
   logic [DATA_WIDTH-1:0]         write_val;
   logic                          valid_out;

   // The feature counter is itself the shared L4 bank address; it is a
   // register, so the address output is glitch-free.
   assign L4_read_addr = feat;

   // Read data arriving this cycle belongs to an address issued RD_LAT
   // cycles ago; the tail of the valid pipe marks it.
   assign valid_out = valid_pipe[RD_LAT-1];

   // Both products are formed at full signed width and sign-extended to the
   // accumulator width before summing, so the accumulator simply wraps.
   always_comb begin
      prod_a  = PROD_WIDTH'($signed(L4_read_data1)) * PROD_WIDTH'($signed(L5_weight_douta));
      prod_b  = PROD_WIDTH'($signed(L4_read_data2)) * PROD_WIDTH'($signed(L5_weight_doutb));
      mac_sum = ACC_WIDTH'(prod_a) + ACC_WIDTH'(prod_b);
   end

   // Fixed-point rescale and clamp into the signed output range; the optional
   // ReLU is applied after the clamp.
   always_comb begin
      acc_shift = acc >>> FRAC_BITS;
      write_val = acc_shift[DATA_WIDTH-1:0];
      if (acc_shift > SAT_MAX) begin
         write_val = SAT_MAX[DATA_WIDTH-1:0];
      end else if (acc_shift < SAT_MIN) begin
         write_val = SAT_MIN[DATA_WIDTH-1:0];
      end
`ifdef L5_RELU_EN
      if (write_val[DATA_WIDTH-1]) begin
         write_val = '0;
      end
`endif
   end

   // Main sequencer: issues one address per cycle while streaming, drains the
   // in-flight reads, then writes the neuron result and moves to the next one.
   // Dropping L5_en anywhere outside IDLE aborts the run back to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         feat            <= '0;
         out_idx         <= '0;
         drain_cnt       <= '0;
         valid_pipe      <= '0;
         acc             <= '0;
         L5_weight_addra <= '0;
         L5_weight_addrb <= '0;
         L5_out_addr     <= '0;
         L5_out_data     <= '0;
         L5_out_wea      <= 1'b0;
         L5_busy         <= 1'b0;
         L5_done         <= 1'b0;
      end else if ((state != IDLE) && !L5_en) begin
         state           <= IDLE;
         feat            <= '0;
         out_idx         <= '0;
         drain_cnt       <= '0;
         valid_pipe      <= '0;
         acc             <= '0;
         L5_weight_addra <= '0;
         L5_weight_addrb <= '0;
         L5_out_wea      <= 1'b0;
         L5_busy         <= 1'b0;
         L5_done         <= 1'b0;
      end else begin
         L5_out_wea    <= 1'b0;
         valid_pipe[0] <= (state == STREAM);
         for (int i = 1; i < RD_LAT; i++) begin
            valid_pipe[i] <= valid_pipe[i-1];
         end
         if (valid_out) begin
            acc <= acc + mac_sum;
         end

         case (state)
            IDLE: begin
               if (L5_en) begin
                  state           <= STREAM;
                  feat            <= '0;
                  out_idx         <= '0;
                  L5_weight_addra <= '0;
                  L5_weight_addrb <= BASE_B;
                  L5_busy         <= 1'b1;
                  L5_done         <= 1'b0;
               end
            end

            STREAM: begin
               if (feat == FEAT_LAST) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end else begin
                  feat            <= feat + 8'd1;
                  L5_weight_addra <= L5_weight_addra + 16'd1;
                  L5_weight_addrb <= L5_weight_addrb + 16'd1;
               end
            end

            DRAIN: begin
               if (drain_cnt == DRAIN_LAST) begin
                  state <= WRITE;
               end else begin
                  drain_cnt <= drain_cnt + DRAIN_W'(1);
               end
            end

            WRITE: begin
               acc         <= '0;
               L5_out_data <= write_val;
               L5_out_addr <= out_idx;
               L5_out_wea  <= 1'b1;
               if (out_idx == OUT_LAST) begin
                  state   <= DONE;
                  L5_busy <= 1'b0;
                  L5_done <= 1'b1;
               end else begin
                  // Weight rows are contiguous, so the next neuron's first
                  // weight sits directly after the last one just read.
                  state           <= STREAM;
                  out_idx         <= out_idx + 7'd1;
                  feat            <= '0;
                  L5_weight_addra <= L5_weight_addra + 16'd1;
                  L5_weight_addrb <= L5_weight_addrb + 16'd1;
               end
            end

            DONE: begin
               state <= DONE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
